// File: rtl/axis_sync_fifo.sv
// AXI-Stream synchronous FIFO: stores full beat payload, registered head-of-queue
// output, beat level and complete-packet count.
module axis_sync_fifo #(
   parameter int unsigned TDATA_WIDTH = 8,
   parameter int unsigned TDEST_WIDTH = 8,
   parameter int unsigned TUSER_WIDTH = 1,
   parameter int unsigned TID_WIDTH   = 8,
   parameter int unsigned DEPTH       = 16
) (
   input  logic                         ACLK,
   input  logic                         ARESETn,
   input  logic                         s_tvalid,
   output logic                         s_tready,
   input  logic [TDATA_WIDTH-1:0]       s_tdata,
   input  logic [TDATA_WIDTH/8-1:0]     s_tkeep,
   input  logic [TDATA_WIDTH/8-1:0]     s_tstrb,
   input  logic                         s_tlast,
   input  logic [TID_WIDTH-1:0]         s_tid,
   input  logic [TDEST_WIDTH-1:0]       s_tdest,
   input  logic [TUSER_WIDTH-1:0]       s_tuser,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [TDATA_WIDTH-1:0]       m_tdata,
   output logic [TDATA_WIDTH/8-1:0]     m_tkeep,
   output logic [TDATA_WIDTH/8-1:0]     m_tstrb,
   output logic                         m_tlast,
   output logic [TID_WIDTH-1:0]         m_tid,
   output logic [TDEST_WIDTH-1:0]       m_tdest,
   output logic [TUSER_WIDTH-1:0]       m_tuser,
   output logic [$clog2(DEPTH):0]       level,
   output logic [$clog2(DEPTH):0]       pkt_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned KW = TDATA_WIDTH / 8;
   localparam int unsigned EW = TDATA_WIDTH + 2*KW + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] s_entry;
   logic [EW-1:0] head_q;
   logic [EW-1:0] head_nx;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr_nx;
   logic [PW-1:0] rd_ptr_nx;
   logic [PW-1:0] level_nx;
   logic [PW-1:0] pkt_nx;
   logic          full;
   logic          wr_en;
   logic          rd_en;

   assign s_entry = {s_tdata, s_tkeep, s_tstrb, s_tlast, s_tid, s_tdest, s_tuser};
   assign {m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser} = head_q;

   // Full when pointers alias the same slot but sit on different laps.
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // Gated by reset so upstream sees no room the instant reset asserts.
   assign s_tready = ARESETn && !full;
   assign wr_en    = s_tvalid && s_tready;
   assign rd_en    = m_tvalid && m_tready;

   // Next pointers, level, packet count and head-of-queue entry.
   always_comb begin
      wr_ptr_nx = wr_ptr;
      rd_ptr_nx = rd_ptr;
      level_nx  = level;
      pkt_nx    = pkt_count;
      head_nx   = head_q;
      if (wr_en) wr_ptr_nx = wr_ptr + PW'(1);
      if (rd_en) rd_ptr_nx = rd_ptr + PW'(1);
      if (wr_en && !rd_en) level_nx = level + PW'(1);
      else if (rd_en && !wr_en) level_nx = level - PW'(1);
      if ((wr_en && s_tlast) && !(rd_en && m_tlast)) pkt_nx = pkt_count + PW'(1);
      else if ((rd_en && m_tlast) && !(wr_en && s_tlast)) pkt_nx = pkt_count - PW'(1);
      // Head is the beat being written if it lands in the new read slot, else storage.
      if (level_nx != '0) begin
         if (wr_en && (wr_ptr == rd_ptr_nx)) head_nx = s_entry;
         else head_nx = mem[rd_ptr_nx[AW-1:0]];
      end
   end

   // Beat storage; no reset needed since contents are only observed via pointers.
   always_ff @(posedge ACLK) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= s_entry;
   end

   // Control and output registers.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         pkt_count <= '0;
         m_tvalid  <= 1'b0;
         head_q    <= '0;
      end else begin
         wr_ptr    <= wr_ptr_nx;
         rd_ptr    <= rd_ptr_nx;
         level     <= level_nx;
         pkt_count <= pkt_nx;
         m_tvalid  <= (level_nx != '0);
         head_q    <= head_nx;
      end
   end

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Bench for axis_sync_fifo: queue-based reference model, hand-computed vector
// table, and directed full/wrap/reset sequences plus randomized backpressure.
module tb_axis_sync_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = 5;

   typedef struct packed {
      logic [7:0] data;
      logic [0:0] keep;
      logic [0:0] strb;
      logic       last;
      logic [7:0] id;
      logic [7:0] dest;
      logic [0:0] user;
   } beat_t;

   typedef struct {
      logic       sv;
      logic [7:0] data;
      logic       last;
      logic       mr;
      int         exp_level;
      int         exp_pkt;
      logic       exp_mvalid;
      logic [7:0] exp_mdata;
      logic       exp_mlast;
   } vec_t;

   logic          ACLK;
   logic          ARESETn;
   logic          s_tvalid;
   logic          s_tready;
   logic [7:0]    s_tdata;
   logic [0:0]    s_tkeep;
   logic [0:0]    s_tstrb;
   logic          s_tlast;
   logic [7:0]    s_tid;
   logic [7:0]    s_tdest;
   logic [0:0]    s_tuser;
   logic          m_tvalid;
   logic          m_tready;
   logic [7:0]    m_tdata;
   logic [0:0]    m_tkeep;
   logic [0:0]    m_tstrb;
   logic          m_tlast;
   logic [7:0]    m_tid;
   logic [7:0]    m_tdest;
   logic [0:0]    m_tuser;
   logic [LW-1:0] level;
   logic [LW-1:0] pkt_count;

   int    n_tests = 0;
   int    n_fail  = 0;
   beat_t mq[$];
   beat_t last_out;
   vec_t  vecs[5];

   axis_sync_fifo #(
      .TDATA_WIDTH(8), .TDEST_WIDTH(8), .TUSER_WIDTH(1), .TID_WIDTH(8), .DEPTH(DEPTH)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .s_tstrb(s_tstrb), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
      .m_tstrb(m_tstrb), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
      .level(level), .pkt_count(pkt_count)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_pkts();
      int n = 0;
      foreach (mq[i]) if (mq[i].last) n++;
      return n;
   endfunction

   function automatic beat_t mk(input logic [7:0] d, input logic l);
      beat_t b;
      b.data = d; b.keep = 1'b1; b.strb = d[0]; b.last = l;
      b.id = d ^ 8'h5A; b.dest = ~d; b.user = l;
      return b;
   endfunction

   function automatic beat_t rnd_beat();
      beat_t b;
      b = beat_t'($urandom);
      b.last = ($urandom_range(0, 3) == 0);
      return b;
   endfunction

   function automatic beat_t dut_out();
      beat_t b;
      b.data = m_tdata; b.keep = m_tkeep; b.strb = m_tstrb; b.last = m_tlast;
      b.id = m_tid; b.dest = m_tdest; b.user = m_tuser;
      return b;
   endfunction

   task automatic chk_model();
      chk("level", 32'(level), 32'(mq.size()));
      chk("pkt_count", 32'(pkt_count), 32'(model_pkts()));
      chk("m_tvalid", 32'(m_tvalid), 32'(mq.size() != 0));
      chk("s_tready", 32'(s_tready), 32'(mq.size() != DEPTH));
      chk("m_payload", 32'(dut_out()), 32'(last_out));
   endtask

   // One clock cycle: drive inputs, advance model at the edge, compare 1 time unit later.
   task automatic step(input logic sv, input beat_t b, input logic mr);
      bit wr, rd;
      s_tvalid = sv;
      s_tdata = b.data; s_tkeep = b.keep; s_tstrb = b.strb; s_tlast = b.last;
      s_tid = b.id; s_tdest = b.dest; s_tuser = b.user;
      m_tready = mr;
      wr = sv && (mq.size() != DEPTH);
      rd = mr && (mq.size() != 0);
      @(posedge ACLK);
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(b);
      if (mq.size() != 0) last_out = mq[0];
      #1;
      chk_model();
   endtask

   task automatic chk_reset_zero(input string tag);
      chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
      chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
      chk({tag, "_level"}, 32'(level), 32'd0);
      chk({tag, "_pkt"}, 32'(pkt_count), 32'd0);
      chk({tag, "_payload"}, 32'(dut_out()), 32'd0);
   endtask

   // Asynchronous reset pulse landing between clock edges; ends 1 unit after a rising edge.
   task automatic pulse_reset(input string tag);
      #2;
      ARESETn = 1'b0;
      #1;
      chk_reset_zero(tag);
      mq.delete();
      last_out = '0;
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      @(negedge ACLK);
      ARESETn = 1'b1;
      @(posedge ACLK);
      #1;
      chk({tag, "_rel_s_tready"}, 32'(s_tready), 32'd1);
      chk({tag, "_rel_m_tvalid"}, 32'(m_tvalid), 32'd0);
   endtask

   initial begin
      beat_t b;
      ARESETn = 1'b0;
      s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tstrb = '0; s_tlast = 1'b0;
      s_tid = '0; s_tdest = '0; s_tuser = '0; m_tready = 1'b0;
      last_out = '0;

      // Hand-derived: 0x11..0x14 streamed through with m_tready held high.
      vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1, 0, 1'b1, 8'h11, 1'b0};
      vecs[1] = '{1'b1, 8'h12, 1'b0, 1'b1, 1, 0, 1'b1, 8'h12, 1'b0};
      vecs[2] = '{1'b1, 8'h13, 1'b0, 1'b1, 1, 0, 1'b1, 8'h13, 1'b0};
      vecs[3] = '{1'b1, 8'h14, 1'b1, 1'b1, 1, 1, 1'b1, 8'h14, 1'b1};
      vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0, 8'h14, 1'b1};

      #3;
      chk_reset_zero("por");
      @(negedge ACLK);
      ARESETn = 1'b1;
      @(posedge ACLK);
      #1;
      chk("por_rel_s_tready", 32'(s_tready), 32'd1);

      // Basic packet through an idle FIFO.
      for (int i = 0; i < 5; i++) begin
         step(vecs[i].sv, mk(vecs[i].data, vecs[i].last), vecs[i].mr);
         chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
         chk($sformatf("vec%0d_pkt", i), 32'(pkt_count), 32'(vecs[i].exp_pkt));
         chk($sformatf("vec%0d_mvalid", i), 32'(m_tvalid), 32'(vecs[i].exp_mvalid));
         chk($sformatf("vec%0d_mdata", i), 32'(m_tdata), 32'(vecs[i].exp_mdata));
         chk($sformatf("vec%0d_mlast", i), 32'(m_tlast), 32'(vecs[i].exp_mlast));
      end

      // Fill to DEPTH with downstream stalled.
      for (int i = 0; i < 16; i++) step(1'b1, mk(8'(8'h20 + i), (i % 4) == 3), 1'b0);
      chk("fill_level", 32'(level), 32'd16);
      chk("fill_s_tready", 32'(s_tready), 32'd0);
      chk("fill_head", 32'(m_tdata), 32'h20);
      // 17th beat held upstream while stalled.
      step(1'b1, mk(8'h99, 1'b1), 1'b0);
      chk("hold17_level", 32'(level), 32'd16);
      // Full with simultaneous valid/ready: read only.
      step(1'b1, mk(8'h99, 1'b1), 1'b1);
      chk("fullrw_level", 32'(level), 32'd15);
      chk("fullrw_head", 32'(m_tdata), 32'h21);
      step(1'b1, mk(8'h99, 1'b1), 1'b0);
      chk("refill_level", 32'(level), 32'd16);

      // Drain to 5, then 40 cycles of concurrent traffic (pointers lap twice).
      for (int i = 0; i < 11; i++) step(1'b0, mk(8'h00, 1'b0), 1'b1);
      chk("drain5_level", 32'(level), 32'd5);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, mk(8'(8'h40 + i), (i % 3) == 0), 1'b1);
         chk($sformatf("steady%0d_level", i), 32'(level), 32'd5);
      end
      for (int i = 0; i < 6; i++) step(1'b0, mk(8'h00, 1'b0), 1'b1);
      chk("drained_mvalid", 32'(m_tvalid), 32'd0);
      chk("drained_hold_last", 32'(m_tdata), 32'(8'h40 + 39));

      // Random backpressure with random sideband.
      for (int i = 0; i < 800; i++) begin
         b = rnd_beat();
         step(($urandom_range(0, 99) < 60), b, ($urandom_range(0, 99) < 45));
      end

      // Reset mid-operation from level 7, two packets.
      pulse_reset("mid0");
      for (int i = 0; i < 7; i++) step(1'b1, mk(8'(8'h60 + i), (i == 2) || (i == 6)), 1'b0);
      chk("pre_rst_level", 32'(level), 32'd7);
      chk("pre_rst_pkt", 32'(pkt_count), 32'd2);
      pulse_reset("mid1");
      step(1'b1, mk(8'hA5, 1'b1), 1'b0);
      chk("fresh_level", 32'(level), 32'd1);
      chk("fresh_pkt", 32'(pkt_count), 32'd1);
      chk("fresh_mdata", 32'(m_tdata), 32'hA5);
      step(1'b0, mk(8'h00, 1'b0), 1'b1);
      chk("fresh_empty", 32'(m_tvalid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_sync_fifo.md
AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 8, data width in bits (multiple of 8).
REQ-002 SHALL have parameter TDEST_WIDTH, default 8, TDEST width.
REQ-003 SHALL have parameter TUSER_WIDTH, default 1, TUSER width.
REQ-004 SHALL have parameter TID_WIDTH, default 8, TID width.
REQ-005 SHALL have parameter DEPTH, default 16, entry count (power of 2, >= 2).
REQ-006 SHALL have ACLK  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have ARESETn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have s_tvalid  input  1  upstream beat valid.
REQ-009 SHALL have s_tready  output  1  FIFO can accept a beat.
REQ-010 SHALL have s_tdata  input  TDATA_WIDTH  upstream data.
REQ-011 SHALL have s_tkeep  input  TDATA_WIDTH/8  upstream byte keep.
REQ-012 SHALL have s_tstrb  input  TDATA_WIDTH/8  upstream byte strobe.
REQ-013 SHALL have s_tlast  input  1  upstream packet end.
REQ-014 SHALL have s_tid  input  TID_WIDTH  upstream stream ID.
REQ-015 SHALL have s_tdest  input  TDEST_WIDTH  upstream routing.
REQ-016 SHALL have s_tuser  input  TUSER_WIDTH  upstream sideband.
REQ-017 SHALL have m_tvalid  output  1  downstream beat valid.
REQ-018 SHALL have m_tready  input  1  downstream accepts beat.
REQ-019 SHALL have m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser  outputs  widths as s_ counterparts  downstream payload.
REQ-020 SHALL have level  output  $clog2(DEPTH)+1  beats stored (0..DEPTH).
REQ-021 SHALL have pkt_count  output  $clog2(DEPTH)+1  complete packets (TLAST beats) stored.

Function
REQ-022 Write SHALL occur on rising edge when s_tvalid && s_tready; full payload (data, keep, strb, last, id, dest, user) stored as one entry.
REQ-023 Read SHALL occur on rising edge when m_tvalid && m_tready; entry removed, next entry presented the following cycle.
REQ-024 s_tready SHALL equal (level != DEPTH) while out of reset; no write-through when full, even with simultaneous read.
REQ-025 m_tvalid SHALL equal (level != 0); no combinational bypass: beat written at edge N SHALL first be visible on m_ at edge N (i.e. m_tvalid high in cycle after write), latency 1 cycle.
REQ-026 While m_tvalid && !m_tready, all m_ payload SHALL remain stable (AXI-Stream rule); m_tvalid SHALL never drop without a read.
REQ-027 Order SHALL be strict FIFO; no beat lost, duplicated or reordered; TLAST carried unmodified.
REQ-028 Read/write pointers SHALL be $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full = MSBs differ and low bits equal, empty = pointers equal.
REQ-029 Simultaneous read and write when 0 < level < DEPTH SHALL leave level unchanged and both SHALL complete.
REQ-030 level SHALL update: +1 write only, -1 read only, 0 both/none; registered, valid the cycle after the edge.
REQ-031 pkt_count SHALL +1 on write with s_tlast=1, -1 on read with m_tlast=1, unchanged if both or neither.
REQ-032 m_ payload when m_tvalid=0 SHALL hold last driven value (no X propagation after first write).

Reset
REQ-033 While ARESETn=0: s_tready=0, m_tvalid=0, level=0, pkt_count=0, pointers=0, m_ payload=0; effect immediate (asynchronous).
REQ-034 Reset mid-operation SHALL discard all stored beats; first rising edge after ARESETn rises SHALL see s_tready=1, m_tvalid=0.

Verification
REQ-035 Reset, 4 beats 0x11..0x14 (last on 0x14), m_tready=1 -> out 0x11..0x14 in order, first m_tvalid one cycle after first write, pkt_count 1 then 0.
REQ-036 m_tready=0, write 16 beats (DEPTH=16) -> level=16, s_tready=0; 17th beat held upstream, accepted after one read.
REQ-037 Full FIFO, s_tvalid=1 and m_tready=1 same cycle -> only read occurs, level 15, then write next cycle, level 16.
REQ-038 Level 5, continuous simultaneous read/write for 40 cycles -> level stays 5, pointers wrap twice, data order intact.
REQ-039 Backpressure: m_tready toggled pseudo-randomly -> m_ payload stable while stalled, TKEEP/TSTRB/TID/TDEST/TUSER match per beat.
REQ-040 ARESETn pulsed low with level 7, pkt_count 2 -> outputs zero asynchronously, after release empty FIFO accepts fresh data.
